// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared constants and types for the multiplexed four-digit seven-segment driver.
package seven_seg_scan_driver_pkg;

  // Default timing: 1 kHz per digit at 100 MHz, 20 us anti-ghost gap, ~1 s blink half-period.
  localparam int DEF_DIGIT_TICKS  = 100000;
  localparam int DEF_BLANK_TICKS  = 2000;
  localparam int DEF_BLINK_FRAMES = 256;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Digit slot index; the value also selects the anode bit it drives.
  typedef enum logic [1:0] {
    DIG_R_ONES = 2'd0,
    DIG_R_TENS = 2'd1,
    DIG_L_ONES = 2'd2,
    DIG_L_TENS = 2'd3
  } digit_idx_e;

  // Frame-stable copy of the display inputs.
  typedef struct packed {
    logic [7:0] left;
    logic [7:0] right;
    logic       lz;
  } shadow_t;

  // Tens slots are the only ones subject to leading-zero suppression.
  function automatic logic is_tens(input digit_idx_e idx);
    return (idx == DIG_R_TENS) || (idx == DIG_L_TENS);
  endfunction

endpackage

// File: rtl/seven_seg_scan_driver_bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment pattern; non-decimal codes show a dash.
module bcd_to_seg7
  import seven_seg_scan_driver_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Decode one nibble to its segment pattern.
  always_comb begin
    // NOTE: every path assigns seg (default arm below), so no latch is inferred.
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver with per-frame input shadowing,
// anti-ghost blanking, leading-zero suppression and whole-display blinking.
module seven_seg_scan_driver
  import seven_seg_scan_driver_pkg::*;
#(
  parameter int DIGIT_TICKS  = DEF_DIGIT_TICKS,
  parameter int BLANK_TICKS  = DEF_BLANK_TICKS,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] display_left,
  input  logic [7:0] display_right,
  input  logic       lz_suppress,
  input  logic       blink_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int TW = $clog2(DIGIT_TICKS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [TW-1:0] tick_q, tick_d;
  digit_idx_e    idx_q, idx_d;
  shadow_t       shadow_q, shadow_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_q, blink_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic          slot_wrap;
  logic          frame_load;
  logic [3:0]    nibble;
  logic [6:0]    dec_seg;

  assign slot_wrap  = (tick_q == TW'(DIGIT_TICKS - 1));
  assign frame_load = slot_wrap && (idx_q == DIG_L_TENS);

  // All state registers; reset clears the scan position, shadows and blink state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q      <= '0;
      idx_q       <= DIG_R_ONES;
      shadow_q    <= '0;
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
      an_q        <= 4'hF;
      seg_q       <= SEG_BLANK;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      tick_q      <= tick_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  // Slot timer, digit index and frame-boundary shadow capture.
  always_comb begin
    tick_d   = slot_wrap ? '0 : tick_q + TW'(1);
    idx_d    = slot_wrap ? digit_idx_e'(idx_q + 2'd1) : idx_q;
    shadow_d = shadow_q;
    if (frame_load) begin
      shadow_d.left  = display_left;
      shadow_d.right = display_right;
      shadow_d.lz    = lz_suppress;
    end
  end

  // Blink frame counter and phase; parked at zero while blinking is disabled.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (!blink_en) begin
      frame_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (frame_load) begin
      if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end
  end

  // Pick the shadowed nibble shown in the current slot.
  always_comb begin
    nibble = shadow_q.right[3:0];
    case (idx_q)
      DIG_R_ONES: nibble = shadow_q.right[3:0];
      DIG_R_TENS: nibble = shadow_q.right[7:4];
      DIG_L_ONES: nibble = shadow_q.left[3:0];
      DIG_L_TENS: nibble = shadow_q.left[7:4];
      default:    nibble = shadow_q.right[3:0];
    endcase
  end

  bcd_to_seg7 u_bcd_to_seg7 (
    .bcd (nibble),
    .seg (dec_seg)
  );

  // Next anode/segment values: blank during the anti-ghost gap and the blink-off phase.
  always_comb begin
    seg_d = dec_seg;
    if (shadow_q.lz && is_tens(idx_q) && (nibble == 4'd0)) begin
      seg_d = SEG_BLANK;
    end
    an_d = ~(4'b0001 << idx_q);
    if ((tick_q < TW'(BLANK_TICKS)) || (blink_en && blink_q)) begin
      an_d = 4'hF;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = 1'b1;
  assign frame_tick = frame_load;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver with DIGIT_TICKS=4, BLANK_TICKS=1, BLINK_FRAMES=2.
// Stimulus drives one vector per frame_tick and queues the frame it expects to be shown next;
// the monitor pops one entry per frame_tick and checks every slot of the following frame.
module tb_seven_seg_scan_driver;

  localparam int DT         = 4;
  localparam int BT         = 1;
  localparam int BF         = 2;
  localparam int TICK_LIMIT = 64;
  localparam int NV         = 14;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] display_left = 8'h00;
  logic [7:0] display_right = 8'h00;
  logic       lz_suppress = 1'b0;
  logic       blink_en = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  seven_seg_scan_driver #(
    .DIGIT_TICKS  (DT),
    .BLANK_TICKS  (BT),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .display_left  (display_left),
    .display_right (display_right),
    .lz_suppress   (lz_suppress),
    .blink_en      (blink_en),
    .an            (an),
    .seg           (seg),
    .dp            (dp),
    .frame_tick    (frame_tick)
  );

  always #5 clk = ~clk;

  // seg[k] is the expected pattern of slot k; on[k]=1 means anode k is driven in that slot.
  typedef struct packed {
    logic [3:0][6:0] seg;
    logic [3:0]      on;
  } exp_t;

  typedef struct packed {
    logic       drive;
    logic [7:0] left;
    logic [7:0] right;
    logic       lz;
    logic       blink;
    logic       mid_en;
    logic [7:0] mid_right;
    logic       mid_blink;
    exp_t       exp;
  } vec_t;

  vec_t vecs [NV];
  exp_t sb_q [$];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic drive, input logic [7:0] left, input logic [7:0] right,
                              input logic lz, input logic blink, input logic mid_en,
                              input logic [7:0] mid_right, input logic mid_blink,
                              input logic [27:0] segs, input logic [3:0] on);
    vec_t v;
    v.drive     = drive;
    v.left      = left;
    v.right     = right;
    v.lz        = lz;
    v.blink     = blink;
    v.mid_en    = mid_en;
    v.mid_right = mid_right;
    v.mid_blink = mid_blink;
    v.exp.seg   = segs;
    v.exp.on    = on;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Wait (bounded) for the negedge at which frame_tick is high.
  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TICK_LIMIT; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Directed vectors. Segment lists are written slot3, slot2, slot1, slot0.
  initial begin
    //            drv  left   right  lz    blk   mid   mid_r  mid_b  segs                                  on
    vecs[0]  = mk(1'b1, 8'h25, 8'h07, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, {7'h24, 7'h12, 7'h40, 7'h78}, 4'b1111);
    // right changes to 13 during slot 1: this frame still shows 07
    vecs[1]  = mk(1'b1, 8'h25, 8'h07, 1'b0, 1'b0, 1'b1, 8'h13, 1'b0, {7'h24, 7'h12, 7'h40, 7'h78}, 4'b1111);
    // pins left untouched: the mid-frame 13 is what loads now
    vecs[2]  = mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, {7'h24, 7'h12, 7'h79, 7'h30}, 4'b1111);
    vecs[3]  = mk(1'b1, 8'h00, 8'h07, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, {7'h7F, 7'h40, 7'h7F, 7'h78}, 4'b1111);
    vecs[4]  = mk(1'b1, 8'h3C, 8'h89, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, {7'h30, 7'h3F, 7'h00, 7'h10}, 4'b1111);
    vecs[5]  = mk(1'b1, 8'h0A, 8'h46, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, {7'h7F, 7'h3F, 7'h19, 7'h02}, 4'b1111);
    // ones digits of zero are never suppressed; blink_en rises mid-frame
    vecs[6]  = mk(1'b1, 8'h91, 8'h50, 1'b1, 1'b0, 1'b1, 8'h50, 1'b1, {7'h10, 7'h79, 7'h12, 7'h40}, 4'b1111);
    vecs[7]  = mk(1'b1, 8'h12, 8'h34, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111);
    vecs[8]  = mk(1'b1, 8'h56, 8'h78, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, {7'h12, 7'h02, 7'h78, 7'h00}, 4'b0000);
    vecs[9]  = mk(1'b1, 8'h90, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, {7'h10, 7'h40, 7'h40, 7'h40}, 4'b0000);
    vecs[10] = mk(1'b1, 8'h90, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, {7'h10, 7'h40, 7'h40, 7'h40}, 4'b1111);
    vecs[11] = mk(1'b1, 8'h11, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, {7'h79, 7'h79, 7'h24, 7'h24}, 4'b1111);
    // blink-off frame; blink_en drops during slot 1, display returns from that slot on
    vecs[12] = mk(1'b1, 8'h33, 8'h44, 1'b0, 1'b1, 1'b1, 8'h44, 1'b0, {7'h30, 7'h30, 7'h19, 7'h19}, 4'b1110);
    vecs[13] = mk(1'b1, 8'h25, 8'h07, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, {7'h24, 7'h12, 7'h40, 7'h78}, 4'b1111);
  end

  // Monitor: on each frame_tick pop the expected frame and check each slot of the next frame.
  initial begin : monitor
    bit         ok;
    exp_t       e;
    int         fidx;
    logic [3:0] exp_an;
    fidx = 0;
    wait (rst_n === 1'b1);
    forever begin
      wait_tick(ok);
      if (!ok) begin
        n_checks++;
        n_fail++;
        $display("FAIL monitor frame_tick timeout: got none in %0d cycles, want one", TICK_LIMIT);
      end else begin
        @(negedge clk);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL frame %0d scoreboard: got frame_tick with empty queue, want queued entry", fidx);
        end else begin
          e = sb_q.pop_front();
          for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("frame %0d slot %0d anti-ghost an", fidx, k), 32'(an), 32'hF);
            @(negedge clk);
            exp_an = e.on[k] ? ~(4'b0001 << k) : 4'hF;
            check($sformatf("frame %0d slot %0d an", fidx, k), 32'(an), 32'(exp_an));
            if (e.on[k]) begin
              check($sformatf("frame %0d slot %0d seg", fidx, k), 32'(seg), 32'(e.seg[k]));
            end
            if (k < 3) begin
              repeat (2) @(negedge clk);
            end
          end
        end
        fidx++;
      end
    end
  end

  // Stimulus: reset checks, then one vector per frame_tick, then an asynchronous mid-slot reset.
  initial begin : stimulus
    bit ok;
    repeat (3) @(negedge clk);
    check("reset an", 32'(an), 32'hF);
    check("reset seg", 32'(seg), 32'h7F);
    check("reset dp", 32'(dp), 32'h1);
    check("reset frame_tick", 32'(frame_tick), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first cycle anti-ghost an", 32'(an), 32'hF);
    @(negedge clk);
    check("first slot an", 32'(an), 32'hE);
    check("first slot seg zero", 32'(seg), 32'h40);
    repeat (4) @(negedge clk);
    check("first frame slot1 an", 32'(an), 32'hD);
    check("first frame slot1 seg zero", 32'(seg), 32'h40);

    for (int v = 0; v < NV; v++) begin
      wait_tick(ok);
      if (!ok) begin
        n_checks++;
        n_fail++;
        $display("FAIL stimulus frame_tick timeout before vector %0d: got none, want one", v);
        break;
      end
      if (vecs[v].drive) begin
        display_left  = vecs[v].left;
        display_right = vecs[v].right;
        lz_suppress   = vecs[v].lz;
        blink_en      = vecs[v].blink;
      end
      sb_q.push_back(vecs[v].exp);
      if (vecs[v].mid_en) begin
        repeat (6) @(negedge clk);
        display_right = vecs[v].mid_right;
        blink_en      = vecs[v].mid_blink;
      end
    end

    // Let the monitor finish the last frame (last vector has no mid-frame action).
    repeat (15) @(negedge clk);
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);

    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset an", 32'(an), 32'hF);
    check("async reset seg", 32'(seg), 32'h7F);
    check("async reset frame_tick", 32'(frame_tick), 32'h0);
    check("async reset dp", 32'(dp), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test by 200000 ns, want earlier finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seven_seg_scan_driver.md
SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 Parameter DIGIT_TICKS, default 100000, is the number of clk cycles per digit slot (1 kHz per digit at 100 MHz); it SHALL be at least 2.
REQ-002 Parameter BLANK_TICKS, default 2000, is the number of anti-ghost cycles at the start of each slot; it SHALL satisfy 1 <= BLANK_TICKS < DIGIT_TICKS.
REQ-003 Parameter BLINK_FRAMES, default 256, is the number of frames per blink half-period; it SHALL be at least 1.
REQ-004 Port clk, input, 1 bit: clock; all state SHALL update on the rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port display_left, input, 8 bits: BCD value, [7:4] tens and [3:0] ones, for the left digit pair.
REQ-007 Port display_right, input, 8 bits: BCD value, [7:4] tens and [3:0] ones, for the right digit pair.
REQ-008 Port lz_suppress, input, 1 bit: when 1, blanks a tens digit whose value is 0.
REQ-009 Port blink_en, input, 1 bit: when 1, enables whole-display blinking.
REQ-010 Port an, output, 4 bits: digit anodes, active-low; an[3] is leftmost.
REQ-011 Port seg, output, 7 bits: segment cathodes, active-low, ordered {g,f,e,d,c,b,a}.
REQ-012 Port dp, output, 1 bit: decimal point, active-low; it SHALL be constant 1.
REQ-013 Port frame_tick, output, 1 bit: one-cycle pulse issued when the shadow registers load.

Function
REQ-014 Tick counter: counts 0..DIGIT_TICKS-1, wraps to 0; at each wrap the digit index SHALL advance 0->1->2->3->0.
REQ-015 Digit mapping: index 0 = right ones, 1 = right tens, 2 = left ones, 3 = left tens; index i drives an[i].
REQ-016 Shadow load: when the tick counter wraps while the index is 3, display_left, display_right and lz_suppress SHALL load into shadow registers and frame_tick SHALL pulse in that same cycle.
REQ-017 Input changes SHALL NOT affect outputs until the next shadow load; a frame never mixes old and new values.
REQ-018 Blanking: while tick < BLANK_TICKS, an SHALL be 4'hF; otherwise an SHALL be one-hot low at the current index.
REQ-019 Segment decode: values 0-9 SHALL use standard patterns (0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10); values A-F SHALL show a dash, 7'h3F.
REQ-020 Leading zero: if the shadow lz_suppress is 1 and a tens nibble is 0, seg SHALL be 7'h7F during that slot, with the anode still driven; ones digits SHALL never be suppressed.
REQ-021 Blink: a frame counter counts frame_tick pulses modulo BLINK_FRAMES and the blink phase toggles at each wrap.
REQ-022 When blink_en=1 and blink phase=1, an SHALL be 4'hF.
REQ-023 When blink_en=0, the blink phase SHALL be forced to 0 and the frame counter held at 0.
REQ-024 an and seg SHALL be registered, with exactly one clk of latency from the counter/index state that selects them.
REQ-025 When blink_en is asserted mid-frame, counting SHALL start at the next frame_tick, and the first blank half-period SHALL begin after BLINK_FRAMES frames.

Reset
REQ-026 While rst_n=0: an=4'hF, seg=7'h7F, dp=1, frame_tick=0, tick=0, index=0, shadows=0, frame counter=0, blink phase=0.
REQ-027 Reset asserted mid-slot SHALL take effect immediately and asynchronously.
REQ-028 After release, the first slot SHALL be index 0 and the first shadow load SHALL occur 4*DIGIT_TICKS cycles later; until then 0s are displayed (or blanks where lz_suppress applies).

Structure
REQ-029 Shared package: segment pattern constants (digits 0-9, DASH, BLANK), digit-index constants, and the default DIGIT_TICKS/BLANK_TICKS/BLINK_FRAMES values.
REQ-030 One combinational sub-module, bcd_to_seg7 (4-bit in, 7-bit active-low out), shall implement REQ-019; all sequencing SHALL stay in the top module.

Verification (DIGIT_TICKS=4, BLANK_TICKS=1, BLINK_FRAMES=2)
REQ-031 Reset: hold rst_n=0 -> an=F, seg=7F, dp=1; release -> first non-blank slot shows an=4'b1110.
REQ-032 display_left=8'h25, display_right=8'h07, after first frame_tick -> slots 0..3 show seg 78, 40, 12, 24 with an 1110, 1101, 1011, 0111.
REQ-033 Change display_right to 8'h13 during slot 1 -> current frame still shows 07; next frame shows 13.
REQ-034 lz_suppress=1, right=8'h07, left=8'h00 -> slot 1 and slot 3 seg=7F with anodes driven; slot 0 seg=78, slot 2 seg=40.
REQ-035 display_left=8'h3C -> slot 2 seg=3F (dash), slot 3 seg=30.
REQ-036 blink_en=1 -> 2 frames with normal an, 2 frames with an=F, repeating; deassert -> normal display from the next cycle.
